demux_1to2_stream: RTL

Buffered 1-to-2 stream demultiplexer: the steering counterpart of the 2-to-1 operand muxes. It accepts one word per cycle on a valid/ready input and routes it, per a select bit sampled with the word, into one of two independent output channels. Each channel holds a 2-entry FIFO, so a stalled consumer never blocks words headed to the other channel that are already buffered. It sits between the ALU result path and its two consumers, for example the register writeback and the store path.

---
 rtl/demux_1to2_stream.sv | 109 ++++++++++
 1 files changed

// File: rtl/demux_1to2_stream.sv
// Buffered 1-to-2 stream demultiplexer with a 2-entry FIFO per output channel.
// Define DEMUX_COUNT_EN to add per-channel delivered-word counters (o_out0_count/o_out1_count).
module demux_1to2_stream #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic             i_in_sel,
  input  logic [WIDTH-1:0] i_in_data,
  output logic             o_out0_valid,
  input  logic             i_out0_ready,
  output logic [WIDTH-1:0] o_out0_data,
  output logic             o_out1_valid,
  input  logic             i_out1_ready,
  output logic [WIDTH-1:0] o_out1_data
`ifdef DEMUX_COUNT_EN
  ,
  output logic [CNT_W-1:0] o_out0_count,
  output logic [CNT_W-1:0] o_out1_count
`endif
);

  logic [1:0]       w_out_ready;
  logic [1:0]       w_out_valid;
  logic [1:0]       w_full;
  logic [1:0]       w_push;
  logic [1:0]       w_pop;
  logic [WIDTH-1:0] w_out_data [2];
  logic             w_in_fire;
`ifdef DEMUX_COUNT_EN
  logic [CNT_W-1:0] w_count [2];
`endif

  assign w_out_ready = {i_out1_ready, i_out0_ready};

  // Ready looks only at the selected FIFO's registered fill level; a same-cycle pop never helps.
  assign o_in_ready = ~w_full[i_in_sel];
  assign w_in_fire  = i_in_valid & o_in_ready;

  for (genvar c = 0; c < 2; c++) begin : g_chan
    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_occ;
    logic [1:0]       w_occ_d;

    assign w_push[c]      = w_in_fire & (i_in_sel == 1'(c));
    assign w_out_valid[c] = (r_occ != 2'd0);
    assign w_full[c]      = (r_occ == 2'd2);
    assign w_pop[c]       = w_out_valid[c] & w_out_ready[c];
    assign w_out_data[c]  = r_mem[r_rd_ptr];

    always_comb begin
      w_occ_d = r_occ;
      if (w_push[c] && !w_pop[c]) begin
        w_occ_d = r_occ + 2'd1;
      end else if (!w_push[c] && w_pop[c]) begin
        w_occ_d = r_occ - 2'd1;
      end
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_mem[0] <= '0;
        r_mem[1] <= '0;
        r_wr_ptr <= 1'b0;
        r_rd_ptr <= 1'b0;
        r_occ    <= 2'd0;
      end else begin
        if (w_push[c]) begin
          r_mem[r_wr_ptr] <= i_in_data;
          r_wr_ptr        <= ~r_wr_ptr;
        end
        if (w_pop[c]) begin
          r_rd_ptr <= ~r_rd_ptr;
        end
        r_occ <= w_occ_d;
      end
    end

`ifdef DEMUX_COUNT_EN
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_count <= '0;
      end else if (w_pop[c]) begin
        r_count <= r_count + 1'b1;
      end
    end

    assign w_count[c] = r_count;
`endif
  end

  assign o_out0_valid = w_out_valid[0];
  assign o_out1_valid = w_out_valid[1];
  assign o_out0_data  = w_out_data[0];
  assign o_out1_data  = w_out_data[1];

`ifdef DEMUX_COUNT_EN
  assign o_out0_count = w_count[0];
  assign o_out1_count = w_count[1];
`endif

endmodule
